dnn_mem_stream_reader: RTL and testbench

Avalon-MM read master that sits directly upstream of the accelerator's 32-bit on-chip weight/activation RAM (8192 words, single port, 1-cycle read latency) and converts a programmed block read into a valid/ready word stream for the DNN datapath. It issues back-to-back reads, absorbs the fixed memory latency in a small credit-controlled FIFO, and sustains one word per cycle while the consumer is ready.

---
 rtl/dnn_accel_pkg.sv | 21 ++
 rtl/dnn_sync_fifo.sv | 68 ++++++
 rtl/dnn_mem_stream_reader.sv | 174 +++++++++++++++++
 tb/tb_dnn_mem_stream_reader.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_accel_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dnn_accel_pkg : shared widths, RAM geometry and reader state type
// Rev 1.0
// ------------------------------------------------------------------
package dnn_accel_pkg;

  localparam int DNN_ADDR_W     = 13;
  localparam int DNN_DATA_W     = 32;
  localparam int DNN_CNT_W      = 14;
  localparam int DNN_RAM_DEPTH  = 8192;
  localparam int DNN_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage : dnn_accel_pkg
`default_nettype wire

// File: rtl/dnn_sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// dnn_sync_fifo : single-clock FIFO with occupancy count and head word
// Rev 1.0
// ------------------------------------------------------------------
module dnn_sync_fifo
  import dnn_accel_pkg::*;
#(
  parameter int DEPTH = DNN_FIFO_DEPTH,
  parameter int WIDTH = DNN_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic [WIDTH-1:0]         o_head_data
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];
  assign w_do_push   = i_push & (r_count != c_depth);
  assign w_do_pop    = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : dnn_sync_fifo
`default_nettype wire

// File: rtl/dnn_mem_stream_reader.sv
`default_nettype none
// ------------------------------------------------------------------
// dnn_mem_stream_reader : Avalon-MM block reader -> valid/ready stream
// Optional feature macro: DNN_READER_ABORT_EN (adds abort input). Rev 1.0
// ------------------------------------------------------------------
module dnn_mem_stream_reader
  import dnn_accel_pkg::*;
#(
  parameter int ADDR_W     = DNN_ADDR_W,
  parameter int DATA_W     = DNN_DATA_W,
  parameter int CNT_W      = DNN_CNT_W,
  parameter int FIFO_DEPTH = DNN_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
`ifdef DNN_READER_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int c_fifo_cnt_w = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0]       c_last_addr = ADDR_W'(DNN_RAM_DEPTH - 1);
  localparam logic [CNT_W-1:0]        c_cnt_one   = CNT_W'(1);
  localparam logic [c_fifo_cnt_w:0]   c_depth     = (c_fifo_cnt_w + 1)'(FIFO_DEPTH);

  reader_state_t            r_state;
  reader_state_t            w_state_nxt;
  logic [ADDR_W-1:0]        r_addr;
  logic [ADDR_W-1:0]        w_addr_inc;
  logic [CNT_W-1:0]         r_issue_rem;
  logic [CNT_W-1:0]         r_out_rem;
  logic                     r_inflight;
  logic                     r_done;
  logic                     w_issue;
  logic                     w_load;
  logic                     w_done_set;
  logic                     w_abort;
  logic                     w_pop;
  logic                     w_credit_ok;
  logic [c_fifo_cnt_w-1:0]  w_fifo_count;
  logic [c_fifo_cnt_w:0]    w_occ;
  logic                     w_fifo_empty;
  logic [DATA_W-1:0]        w_head;

`ifdef DNN_READER_ABORT_EN
  assign w_abort = abort & (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign busy           = (r_state != IDLE);
  assign done           = r_done;
  assign mem_address    = r_addr;
  assign mem_chipselect = w_issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign out_valid      = ~w_fifo_empty;
  assign out_data       = w_head;
  assign out_last       = out_valid & (r_out_rem == c_cnt_one);

  assign w_pop      = out_valid & out_ready;
  assign w_addr_inc = (r_addr == c_last_addr) ? '0 : r_addr + 1'b1;

  // Buffered plus in-flight words must leave room for the read about to issue;
  // a pop this cycle frees one slot, so it raises the limit instead of going negative.
  assign w_occ       = {1'b0, w_fifo_count} + {{c_fifo_cnt_w{1'b0}}, r_inflight};
  assign w_credit_ok = w_occ < (c_depth + {{c_fifo_cnt_w{1'b0}}, w_pop});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            w_state_nxt = FETCH;
            w_load      = 1'b1;
          end else begin
            w_done_set = 1'b1;
          end
        end
      end
      FETCH: begin
        w_issue = w_credit_ok;
        if (w_credit_ok && (r_issue_rem == c_cnt_one)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && (r_out_rem == c_cnt_one)) begin
          w_state_nxt = IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = IDLE;
      w_issue     = 1'b0;
      w_load      = 1'b0;
      w_done_set  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_issue_rem <= '0;
      r_out_rem   <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_done_set;
      if (w_load) begin
        r_addr      <= base_addr;
        r_issue_rem <= word_count;
        r_out_rem   <= word_count;
      end else begin
        if (w_issue) begin
          r_addr      <= w_addr_inc;
          r_issue_rem <= r_issue_rem - 1'b1;
        end
        if (w_pop) begin
          r_out_rem <= r_out_rem - 1'b1;
        end
      end
    end
  end

  // RAM data lands one cycle after its strobe; an abort drops it along with the FIFO.
  dnn_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clear     (w_abort),
    .i_push      (r_inflight),
    .i_push_data (mem_readdata),
    .i_pop       (w_pop),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty),
    .o_head_data (w_head)
  );

endmodule : dnn_mem_stream_reader
`default_nettype wire

// File: tb/tb_dnn_mem_stream_reader.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_dnn_mem_stream_reader : randomized bench with a queue-based stream model
// Rev 1.0
// ------------------------------------------------------------------
module tb_dnn_mem_stream_reader;

  localparam int AW        = 13;
  localparam int DW        = 32;
  localparam int CWD       = 14;
  localparam int DEPTH     = 4;
  localparam int RAM_WORDS = 8192;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [CWD-1:0] word_count;
  logic           busy;
  logic           done;
  logic [AW-1:0]  mem_address;
  logic           mem_chipselect;
  logic           mem_write;
  logic [3:0]     mem_byteenable;
  logic           mem_clken;
  logic [DW-1:0]  mem_readdata = '0;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           out_last;
`ifdef DNN_READER_ABORT_EN
  logic           abort;
`endif

  logic [DW-1:0] ram [0:RAM_WORDS-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= ram[mem_address];
  end

  dnn_mem_stream_reader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
`ifdef DNN_READER_ABORT_EN
    .abort          (abort),
`endif
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last)
  );

  // Runs one command; mode 0 = ready always, 1 = ready toggling, 2 = random ready.
  // inject_cyc > 0 pulses a second start that must be ignored.
  task automatic run_stream(input logic [AW-1:0] b, input int n, input int mode,
                            input int inject_cyc, input string tag);
    logic [DW-1:0] exp_data[$];
    int            exp_addr[$];
    int            k, issued, done_cyc, first_valid, budget;
    logic          rdy, prev_stall;
    logic [DW-1:0] prev_data;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back((int'(b) + i) % RAM_WORDS);
      exp_data.push_back(ram[(int'(b) + i) % RAM_WORDS]);
    end
    k = 0; issued = 0; done_cyc = -1; first_valid = -1;
    prev_stall = 1'b0; prev_data = '0;
    budget = 4 * n + 24;
    @(negedge clk);
    start = 1'b1; base_addr = b; word_count = CWD'(n); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL %s stall_hold cyc %0d: valid %b data %h, required valid 1 data %h",
                   tag, cyc, out_valid, out_data, prev_data);
        end
      end
      checks++;
      if (issued - k > DEPTH) begin
        errors++;
        $display("FAIL %s occupancy cyc %0d: %0d words buffered, required <= %0d",
                 tag, cyc, issued - k, DEPTH);
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (done === 1'b1) begin
        checks++;
        if (done_cyc >= 0 || k != n || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_pulse cyc %0d: words %0d busy %b earlier_done %0d, required words %0d busy 0 single pulse",
                   tag, cyc, k, busy, done_cyc, n);
        end
        done_cyc = cyc;
      end else if (done_cyc < 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy cyc %0d: busy %b, required 1", tag, cyc, busy);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s after_done cyc %0d: valid %b busy %b, required 0 0",
                   tag, cyc, out_valid, busy);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_last !== (k == n - 1)) begin
          errors++;
          $display("FAIL %s last word %0d: out_last %b, required %b", tag, k, out_last, (k == n - 1));
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (cyc == inject_cyc) begin
        start = 1'b1; base_addr = AW'($urandom); word_count = CWD'($urandom_range(1, 9));
      end else begin
        start = 1'b0;
      end
      if (out_valid === 1'b1 && rdy) begin
        checks++;
        if (k >= n) begin
          errors++;
          $display("FAIL %s extra_word: data %h beyond %0d words", tag, out_data, n);
        end else if (out_data !== exp_data[k]) begin
          errors++;
          $display("FAIL %s word %0d: data %h, required %h", tag, k, out_data, exp_data[k]);
        end
        k++;
      end
      prev_stall = (out_valid === 1'b1) && !rdy;
      prev_data  = out_data;
      #1;
      if (mem_chipselect === 1'b1) begin
        checks++;
        if (issued >= n) begin
          errors++;
          $display("FAIL %s extra_read: address %h after %0d reads", tag, mem_address, n);
        end else if (mem_address !== AW'(exp_addr[issued])) begin
          errors++;
          $display("FAIL %s read %0d: address %h, required %h",
                   tag, issued, mem_address, AW'(exp_addr[issued]));
        end
        issued++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (done_cyc < 0 || k != n || issued != n) begin
      errors++;
      $display("FAIL %s completion: done_cyc %0d words %0d reads %0d, required done and %0d words/reads",
               tag, done_cyc, k, issued, n);
    end
    if (mode == 0) begin
      checks++;
      if (done_cyc != n + 3 || first_valid != 3) begin
        errors++;
        $display("FAIL %s latency: done at %0d first valid at %0d, required %0d and 3",
                 tag, done_cyc, first_valid, n + 3);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
`ifdef DNN_READER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy %b done %b valid %b last %b, required 0000",
               busy, done, out_valid, out_last);
    end
    checks++;
    if (out_data !== '0 || mem_chipselect !== 1'b0 || mem_address !== '0) begin
      errors++;
      $display("FAIL reset_bus: data %h cs %b addr %h, required 0 0 0",
               out_data, mem_chipselect, mem_address);
    end
    checks++;
    if (mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_clken !== 1'b1) begin
      errors++;
      $display("FAIL reset_const: write %b be %h clken %b, required 0 f 1",
               mem_write, mem_byteenable, mem_clken);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy %b done %b cs %b, required 000", busy, done, mem_chipselect);
    end
  endtask

  task automatic test_basic();
    run_stream(13'h010, 4, 0, 0, "basic");
  endtask

  task automatic test_wrap();
    run_stream(13'h1FFE, 4, 0, 0, "wrap");
  endtask

  task automatic test_stall_toggle();
    run_stream(AW'($urandom), 16, 1, 0, "toggle");
  endtask

  task automatic test_zero_count();
    @(negedge clk);
    start = 1'b1; base_addr = 13'h0123; word_count = '0; out_ready = 1'b1;
    #1;
    checks++;
    if (mem_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL zero_cs: cs %b, required 0", mem_chipselect);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done %b busy %b cs %b, required 1 0 0", done, busy, mem_chipselect);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: done %b busy %b valid %b, required 000", done, busy, out_valid);
    end
  endtask

  task automatic test_start_while_busy();
    run_stream(AW'($urandom), 10, 0, 4, "busy_start");
  endtask

  task automatic test_random();
    for (int i = 0; i < RAM_WORDS; i++) ram[i] = $urandom;
    for (int t = 0; t < 6; t++) begin
      run_stream(AW'($urandom), $urandom_range(1, 40), 2, 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_stream(13'h1FFC, 7, 0, 0, "b2b_a");
    run_stream(13'h0002, 5, 0, 0, "b2b_b");
  endtask

  // Starts a 12-word read and returns after the third word has been accepted.
  task automatic launch_and_take_three(input logic [AW-1:0] b, input string tag);
    int hs;
    hs = 0;
    @(negedge clk);
    start = 1'b1; base_addr = b; word_count = CWD'(12); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && hs < 3; i++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== ram[(int'(b) + hs) % RAM_WORDS]) begin
          errors++;
          $display("FAIL %s word %0d: data %h, required %h",
                   tag, hs, out_data, ram[(int'(b) + hs) % RAM_WORDS]);
        end
        hs++;
      end
      @(negedge clk);
    end
    checks++;
    if (hs != 3) begin
      errors++;
      $display("FAIL %s timeout: %0d words seen, required 3", tag, hs);
    end
  endtask

  task automatic test_reset_mid();
    launch_and_take_three(AW'($urandom), "reset_mid");
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_data !== '0 || mem_chipselect !== 1'b0 || mem_address !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: busy %b done %b valid %b last %b data %h cs %b addr %h, required all 0",
               busy, done, out_valid, out_last, out_data, mem_chipselect, mem_address);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet %0d: done %b busy %b valid %b, required 000",
                 i, done, busy, out_valid);
      end
    end
    run_stream(AW'($urandom), 9, 0, 0, "after_reset");
  endtask

`ifdef DNN_READER_ABORT_EN
  task automatic test_abort();
    launch_and_take_three(AW'($urandom), "abort");
    abort = 1'b1;
    #1;
    checks++;
    if (mem_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL abort_cs: cs %b, required 0", mem_chipselect);
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: valid %b done %b busy %b, required 0 1 0", out_valid, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_single: done %b valid %b, required 0 0", done, out_valid);
    end
    run_stream(AW'($urandom), 6, 0, 0, "after_abort");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) ram[i] = DW'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_stall_toggle();
    test_zero_count();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef DNN_READER_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dnn_mem_stream_reader
`default_nettype wire
